// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, word addresses
// and counter widths.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_RD_ID  = 3'd0,
    ST_WT_ID  = 3'd1,
    ST_RD_TS  = 3'd2,
    ST_WT_TS  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAIL   = 3'd6
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Latency shift register covers READ_LATENCY up to 3; timeout counter up to 65535.
  localparam int unsigned LAT_SR_W  = 3;
  localparam int unsigned TMO_CNT_W = 16;

  function automatic logic is_idle(input sysid_state_e s);
    return (s == ST_DONE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/nios_system_sysid_rd_timer.sv
// Per-read timing: delays the accept strobe by READ_LATENCY into a capture strobe and
// counts cycles since the read started, raising a timeout strobe at TIMEOUT.
module nios_system_sysid_rd_timer
  import nios_system_sysid_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clr_i,
  input  logic accept_i,
  output logic capture_o,
  output logic timeout_o
);

  localparam int unsigned LAT_IDX = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;

  logic [LAT_SR_W-1:0]  lat_sr_q, lat_sr_d;
  logic [TMO_CNT_W-1:0] tmo_q, tmo_d;

  always_comb begin
    lat_sr_d = {lat_sr_q[LAT_SR_W-2:0], (READ_LATENCY != 0) && accept_i};
    tmo_d    = tmo_q;
    if (clr_i) begin
      lat_sr_d = '0;
      tmo_d    = '0;
    end else if (run_i) begin
      tmo_d = tmo_q + TMO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_sr_q <= '0;
      tmo_q    <= '0;
    end else begin
      lat_sr_q <= lat_sr_d;
      tmo_q    <= tmo_d;
    end
  end

  // A capture landing on the last allowed cycle beats the timeout.
  assign capture_o = (READ_LATENCY == 0) ? accept_i : lat_sr_q[LAT_IDX];
  assign timeout_o = run_i && !capture_o && (tmo_q == TMO_CNT_W'(TIMEOUT));

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and timestamp words and checks them
// against build-time values. Build option: SYSID_CHECK_RETRY_EN retries a mismatch.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID       = 32'h0000_0000,
  parameter logic [31:0] EXP_TS       = 32'd1581593513,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitreq,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state_q, state_d;
  logic         id_ok_q, id_ok_d;
  logic         ts_ok_q, ts_ok_d;
  logic         tmo_err_q, tmo_err_d;
  logic [31:0]  id_val_q, id_val_d;
  logic [31:0]  ts_val_q, ts_val_d;

  logic rd_state;
  logic run;
  logic accept;
  logic capture;
  logic timeout;
  logic tmr_clr;

`ifdef SYSID_CHECK_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry_q, retry_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`endif

  assign rd_state = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  assign run      = rd_state || (state_q == ST_WT_ID) || (state_q == ST_WT_TS);
  assign accept   = avm_read && !avm_waitreq;
  assign tmr_clr  = ((state_d == ST_RD_ID) || (state_d == ST_RD_TS)) && (state_d != state_q);

  nios_system_sysid_rd_timer #(
    .READ_LATENCY (READ_LATENCY),
    .TIMEOUT      (TIMEOUT)
  ) u_rd_timer (
    .clk_i     (clock),
    .rst_i     (reset),
    .run_i     (run),
    .clr_i     (tmr_clr),
    .accept_i  (accept),
    .capture_o (capture),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d   = state_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    tmo_err_d = tmo_err_q;
    id_val_d  = id_val_q;
    ts_val_d  = ts_val_q;
`ifdef SYSID_CHECK_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      ST_RD_ID, ST_WT_ID: begin
        if (capture) begin
          id_val_d = avm_readdata;
          state_d  = ST_RD_TS;
        end else if (timeout) begin
          tmo_err_d = 1'b1;
          state_d   = ST_FAIL;
        end else if (accept) begin
          state_d = ST_WT_ID;
        end
      end
      ST_RD_TS, ST_WT_TS: begin
        if (capture) begin
          ts_val_d = avm_readdata;
          state_d  = ST_CHECK;
        end else if (timeout) begin
          tmo_err_d = 1'b1;
          state_d   = ST_FAIL;
        end else if (accept) begin
          state_d = ST_WT_TS;
        end
      end
      ST_CHECK: begin
        id_ok_d = (id_val_q == EXP_ID);
        ts_ok_d = (ts_val_q == EXP_TS);
        if ((id_val_q == EXP_ID) && (ts_val_q == EXP_TS)) begin
          state_d = ST_DONE;
        end else begin
`ifdef SYSID_CHECK_RETRY_EN
          if (retry_q != RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_RD_ID;
          end else begin
            state_d = ST_FAIL;
          end
`else
          state_d = ST_FAIL;
`endif
        end
      end
      ST_DONE, ST_FAIL: begin
        if (start) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          tmo_err_d = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
          retry_d   = '0;
`endif
          state_d   = ST_RD_ID;
        end
      end
      default: state_d = ST_RD_ID;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RD_ID;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      id_val_q  <= '0;
      ts_val_q  <= '0;
    end else begin
      state_q   <= state_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      tmo_err_q <= tmo_err_d;
      id_val_q  <= id_val_d;
      ts_val_q  <= ts_val_d;
    end
  end

  // Reset masks the request outputs so the bus sees nothing while reset is held.
  assign avm_read    = !reset && rd_state;
  assign avm_address = ((state_q == ST_RD_TS) || (state_q == ST_WT_TS)) ? SYSID_ADDR_TS
                                                                       : SYSID_ADDR_ID;
  assign busy        = !reset && !is_idle(state_q);
  assign done        = is_idle(state_q);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_err_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for nios_system_sysid_checker: a zero-latency instance (A) and a READ_LATENCY=2,
// TIMEOUT=15 instance (B), each behind a stall-programmable slave model.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] TSW = 32'd1581593513;
  localparam int MR = 3;
`ifdef SYSID_CHECK_RETRY_EN
  localparam int RM = 1 + MR;
`else
  localparam int RM = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  int          stall_id = 0;
  int          stall_ts = 0;
  logic [31:0] id_word  = 32'h0;
  logic [31:0] ts_word  = TSW;

  logic        rd_a, adr_a, wr_a, busy_a, done_a, idok_a, tsok_a, tmo_a;
  logic [31:0] rdata_a, idv_a, tsv_a;
  logic        rd_b, adr_b, wr_b, busy_b, done_b, idok_b, tsok_b, tmo_b;
  logic [31:0] rdata_b, idv_b, tsv_b;

  nios_system_sysid_checker u_dut_a (
    .clock(clk), .reset(reset), .start(start_a),
    .avm_address(adr_a), .avm_read(rd_a), .avm_waitreq(wr_a), .avm_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a),
    .timeout_err(tmo_a), .id_value(idv_a), .ts_value(tsv_a)
  );

  nios_system_sysid_checker #(.READ_LATENCY(2), .TIMEOUT(15)) u_dut_b (
    .clock(clk), .reset(reset), .start(start_b),
    .avm_address(adr_b), .avm_read(rd_b), .avm_waitreq(wr_b), .avm_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b),
    .timeout_err(tmo_b), .id_value(idv_b), .ts_value(tsv_b)
  );

  // Slave models: waitreq held for the programmed number of cycles of each request.
  int hcnt_a, hcnt_b;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_a <= 0;
      hcnt_b <= 0;
    end else begin
      hcnt_a <= (rd_a && wr_a) ? hcnt_a + 1 : 0;
      hcnt_b <= (rd_b && wr_b) ? hcnt_b + 1 : 0;
    end
  end
  assign wr_a = rd_a && (hcnt_a < (adr_a ? stall_ts : stall_id));
  assign wr_b = rd_b && (hcnt_b < (adr_b ? stall_ts : stall_id));
  assign rdata_a = (rd_a && !wr_a) ? (adr_a ? ts_word : id_word) : 32'hA5A5_A5A5;

  logic p1v, p1a, p2v, p2a;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p1v <= 1'b0; p1a <= 1'b0; p2v <= 1'b0; p2a <= 1'b0;
    end else begin
      p1v <= rd_b && !wr_b; p1a <= adr_b; p2v <= p1v; p2a <= p1a;
    end
  end
  assign rdata_b = p2v ? (p2a ? ts_word : id_word) : 32'h5A5A_5A5A;

  bit          sel = 1'b0;
  wire         rd_s   = sel ? rd_b   : rd_a;
  wire         adr_s  = sel ? adr_b  : adr_a;
  wire         wr_s   = sel ? wr_b   : wr_a;
  wire         busy_s = sel ? busy_b : busy_a;
  wire         done_s = sel ? done_b : done_a;
  wire         idok_s = sel ? idok_b : idok_a;
  wire         tsok_s = sel ? tsok_b : tsok_a;
  wire         tmo_s  = sel ? tmo_b  : tmo_a;
  wire  [31:0] idv_s  = sel ? idv_b  : idv_a;
  wire  [31:0] tsv_s  = sel ? tsv_b  : tsv_a;

  int id_hi = 0;
  int id_acc = 0;
  always @(posedge clk) begin
    if (!reset && rd_s && !adr_s) begin
      id_hi <= id_hi + 1;
      if (!wr_s) id_acc <= id_acc + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference model: each read lasts stall+latency+1 cycles unless that overruns TIMEOUT.
  logic [31:0] mdl_idv[2];
  logic [31:0] mdl_tsv[2];

  task automatic model(input bit d, input int sid, input int sts, input logic [31:0] idw,
                       input logic [31:0] tsw, output int ecyc, output bit eid,
                       output bit ets, output bit etmo);
    int lat, tmo;
    lat = d ? 2 : 0;
    tmo = d ? 15 : 255;
    eid = 1'b0; ets = 1'b0; etmo = 1'b0;
    if (sid + lat > tmo) begin
      ecyc = tmo + 1; etmo = 1'b1;
      return;
    end
    ecyc = sid + lat + 1;
    mdl_idv[d] = idw;
    if (sts + lat > tmo) begin
      ecyc += tmo + 1; etmo = 1'b1;
      return;
    end
    ecyc += sts + lat + 2;
    mdl_tsv[d] = tsw;
    eid = (idw == 32'h0);
    ets = (tsw == TSW);
    if (!(eid && ets)) ecyc *= RM;
  endtask

  task automatic wait_done(input bit d, input int pulse_at, output int cyc);
    cyc = 0;
    while (!done_s) begin
      if (d) start_b = (cyc == pulse_at); else start_a = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
      if (cyc > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL done_wait: no done after %0d cycles, required done=1", cyc);
        break;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run(input bit d, input int pulse_at, input string nm, output int cyc);
    sel = d;
    @(negedge clk);
    if (d) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    chk({nm, "_launch"}, {busy_s, done_s, idok_s, tsok_s, tmo_s}, 5'b10000);
    wait_done(d, pulse_at, cyc);
  endtask

  task automatic check_run(input bit d, input string nm, input int cyc, input int ecyc,
                           input bit eid, input bit ets, input bit etmo, input int sid,
                           input int hi0, input int acc0);
    int att;
    chk({nm, "_cycles"}, cyc, ecyc);
    chk({nm, "_flags"}, {done_s, idok_s, tsok_s, tmo_s}, {1'b1, eid, ets, etmo});
    chk({nm, "_idle"}, {busy_s, rd_s}, 2'b00);
    chk({nm, "_idval"}, idv_s, mdl_idv[d]);
    chk({nm, "_tsval"}, tsv_s, mdl_tsv[d]);
    if (!etmo) begin
      att = (eid && ets) ? 1 : RM;
      chk({nm, "_id_rd_cycles"}, id_hi - hi0, (sid + 1) * att);
      chk({nm, "_id_reads"}, id_acc - acc0, att);
    end
  endtask

  typedef struct {
    bit          d;
    int          sid;
    int          sts;
    logic [31:0] idw;
    logic [31:0] tsw;
    int          cyc;
    bit          eid;
    bit          ets;
    bit          etmo;
  } vec_t;

  vec_t vt[14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    int cyc, ecyc, hi0, acc0;
    bit eid, ets, etmo, found;

    vt[0]  = '{1'b0,   0,   0, 32'h0,         TSW,           3,      1'b1, 1'b1, 1'b0};
    vt[1]  = '{1'b0,   5,   0, 32'h0,         TSW,           8,      1'b1, 1'b1, 1'b0};
    vt[2]  = '{1'b0,   0,   4, 32'h0,         TSW,           7,      1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0,   0,   0, 32'hDEAD_BEEF, TSW,           3 * RM, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b0,   2,   1, 32'h0,         32'h1234_5678, 6 * RM, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 255,   0, 32'h0,         TSW,           258,    1'b1, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 256,   0, 32'h0,         TSW,           256,    1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b0,   0, 300, 32'h0,         TSW,           257,    1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1,  10,   0, 32'h0,         TSW,           17,     1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b1,  13,   0, 32'h0,         TSW,           20,     1'b1, 1'b1, 1'b0};
    vt[10] = '{1'b1,  14,   0, 32'h0,         TSW,           16,     1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b1,   0,  13, 32'h0,         TSW,           20,     1'b1, 1'b1, 1'b0};
    vt[12] = '{1'b1,   0,   0, 32'hDEAD_BEEF, TSW,           7 * RM, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1000,  0, 32'h0,         TSW,           16,     1'b0, 1'b0, 1'b1};

    // Reset state, asserted between clock edges.
    #1 reset = 1'b1;
    #1;
    chk("rst_a", {rd_a, adr_a, busy_a, done_a, idok_a, tsok_a, tmo_a, idv_a, tsv_a}, '0);
    chk("rst_b", {rd_b, adr_b, busy_b, done_b, idok_b, tsok_b, tmo_b, idv_b, tsv_b}, '0);
    repeat (3) @(posedge clk);

    // Minimum-time pass after reset release.
    sel = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1 chk("t1_c0", {rd_a, adr_a, busy_a, done_a}, 4'b1010);
    @(posedge clk); #1 chk("t1_c1", {rd_a, adr_a, done_a, idv_a}, {3'b110, 32'h0});
    @(posedge clk); #1 chk("t1_c2", {rd_a, busy_a, done_a, tsv_a}, {3'b010, TSW});
    @(posedge clk); #1 chk("t1_c3", {done_a, busy_a, idok_a, tsok_a, tmo_a}, 5'b10110);
    repeat (4) @(posedge clk);
    #1 chk("t1_b", {done_b, busy_b, idok_b, tsok_b, tmo_b}, 5'b10110);
    mdl_idv[0] = 32'h0; mdl_idv[1] = 32'h0;
    mdl_tsv[0] = TSW;   mdl_tsv[1] = TSW;

    for (int i = 0; i < 14; i++) begin
      stall_id = vt[i].sid; stall_ts = vt[i].sts;
      id_word  = vt[i].idw; ts_word  = vt[i].tsw;
      model(vt[i].d, vt[i].sid, vt[i].sts, vt[i].idw, vt[i].tsw, ecyc, eid, ets, etmo);
      hi0 = id_hi; acc0 = id_acc;
      run(vt[i].d, -1, $sformatf("vec%0d", i), cyc);
      check_run(vt[i].d, $sformatf("vec%0d", i), cyc, vt[i].cyc, vt[i].eid, vt[i].ets,
                vt[i].etmo, vt[i].sid, hi0, acc0);
    end

    // Asynchronous reset while instance B waits on timestamp data.
    stall_id = 0; stall_ts = 0; id_word = 32'hDEAD_BEEF; ts_word = TSW;
    sel = 1'b1;
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      found = busy_b && adr_b && !rd_b;
    end
    chk("t5_reach_wt_ts", found, 1'b1);
    chk("t5_pre_idval", idv_b, 32'hDEAD_BEEF);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_b", {rd_b, adr_b, busy_b, done_b, idok_b, tsok_b, tmo_b, idv_b, tsv_b}, '0);
    chk("t5_rst_a", {rd_a, adr_a, busy_a, done_a, idok_a, tsok_a, tmo_a, idv_a, tsv_a}, '0);
    id_word = 32'h0;
    @(negedge clk) reset = 1'b0;
    wait_done(1'b1, -1, cyc);
    mdl_idv[0] = 32'h0; mdl_idv[1] = 32'h0;
    mdl_tsv[0] = TSW;   mdl_tsv[1] = TSW;
    chk("t5_rerun_cycles", cyc, 7);
    chk("t5_rerun_flags", {done_b, idok_b, tsok_b, tmo_b, idv_b, tsv_b}, {4'b1110, 32'h0, TSW});
    chk("t5_rerun_a", {done_a, idok_a, tsok_a, tmo_a}, 4'b1110);

    // Start while busy is ignored; start in DONE reruns.
    stall_id = 10; stall_ts = 0;
    model(1'b0, 10, 0, 32'h0, TSW, ecyc, eid, ets, etmo);
    hi0 = id_hi; acc0 = id_acc;
    run(1'b0, 4, "t6_busy_start", cyc);
    check_run(1'b0, "t6_busy_start", cyc, 13, 1'b1, 1'b1, 1'b0, 10, hi0, acc0);
    stall_id = 0;
    model(1'b0, 0, 0, 32'h0, TSW, ecyc, eid, ets, etmo);
    hi0 = id_hi; acc0 = id_acc;
    run(1'b0, -1, "t6_done_start", cyc);
    check_run(1'b0, "t6_done_start", cyc, 3, 1'b1, 1'b1, 1'b0, 0, hi0, acc0);

    // Randomized runs on both instances.
    for (int r = 0; r < 30; r++) begin
      bit d;
      int sid, sts;
      logic [31:0] idw, tsw;
      d = r[0];
      if (d) begin
        sid = $urandom_range(0, 16);
        sts = $urandom_range(0, 16);
      end else begin
        sid = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 260) : $urandom_range(0, 6);
        sts = $urandom_range(0, 6);
      end
      idw = ($urandom_range(0, 2) != 0) ? 32'h0 : $urandom;
      tsw = ($urandom_range(0, 2) != 0) ? TSW : $urandom;
      stall_id = sid; stall_ts = sts; id_word = idw; ts_word = tsw;
      model(d, sid, sts, idw, tsw, ecyc, eid, ets, etmo);
      hi0 = id_hi; acc0 = id_acc;
      run(d, -1, $sformatf("rnd%0d", r), cyc);
      check_run(d, $sformatf("rnd%0d", r), cyc, ecyc, eid, ets, etmo, sid, hi0, acc0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
